// File: rtl/unit_op_pkg.sv
// Shared types and constants for the unit-decoder request initiator.
// Op id 0 means "no completion", so issued ids run 1..255.
package unit_op_pkg;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } state_e;

  localparam logic [7:0] OP_ID_NONE  = 8'd0;
  localparam logic [7:0] OP_ID_FIRST = 8'd1;

  function automatic logic [7:0] nextOpId(input logic [7:0] id);
    return (id == 8'd255) ? OP_ID_FIRST : id + 8'd1;
  endfunction

endpackage

// File: rtl/unit_op_fifo.sv
// Registered command FIFO; a pushed entry becomes visible one edge later.
// o_next exposes the entry behind the head so back-to-back issue can load it.
module unit_op_fifo
  import unit_op_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output cmd_t o_head,
  output cmd_t o_next,
  output logic o_empty,
  output logic o_full,
  output logic o_hasTwo
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] TWO_CNT  = (AW + 1)'(2);

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] w_rdNext;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign w_rdNext = r_rdPtr + AW'(1);
  assign o_head   = r_mem[r_rdPtr];
  assign o_next   = r_mem[w_rdNext];
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign o_hasTwo = (r_count >= TWO_CNT);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= w_rdNext;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/unit_op_initiator.sv
// Request-side master for the unit address decoder: queues commands, tags each
// with an op id, issues them and matches completions against a per-id scoreboard.
module unit_op_initiator
  import unit_op_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       enable_in,
  output logic       wr_rd_op,
  output logic       valid_in,
  output logic [7:0] addr_in,
  output logic [7:0] op_id_in,
  output logic [7:0] wr_data_in,
  input  logic       ready_out,
  input  logic [7:0] rd_data_out,
  input  logic [7:0] done_op_id,
  output logic       rsp_valid,
  output logic [7:0] rsp_op_id,
  output logic       rsp_wr,
  output logic [7:0] rsp_rd_data,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_unexp
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_OUT_L = 8'(MAX_OUT);
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

  state_e        r_state;
  logic          r_valid, r_wr, r_started, r_enable;
  logic [7:0]    r_addr, r_data, r_opId, r_nextId, r_outstanding;
  logic [255:0]  r_pending, r_wrflag, w_pendNext;
  logic [TW-1:0] r_timer;
  logic          r_rspValid, r_rspWr, r_errTimeout, r_errUnexp;
  logic [7:0]    r_rspOpId, r_rspRdData;

  cmd_t       w_cmdIn, w_head, w_next, w_load;
  logic       w_empty, w_full, w_hasTwo, w_push, w_xfer, w_doneHit, w_doneBad;
  logic       w_avail, w_blocked, w_issueOk, w_validNext;
  logic [7:0] w_outNext, w_idNext;

  assign w_cmdIn   = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
  assign w_push    = cmd_valid && cmd_ready;
  assign w_xfer    = r_valid && ready_out;
  assign w_doneHit = (done_op_id != OP_ID_NONE) && r_pending[done_op_id];
  assign w_doneBad = (done_op_id != OP_ID_NONE) && !r_pending[done_op_id];

  unit_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_cmdIn),
    .i_pop   (w_xfer),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_hasTwo(w_hasTwo)
  );

  // Issue decisions look at the scoreboard as it will be after this edge.
  always_comb begin
    w_pendNext = r_pending;
    if (w_xfer)    w_pendNext[r_opId] = 1'b1;
    if (w_doneHit) w_pendNext[done_op_id] = 1'b0;
  end

  assign w_outNext   = r_outstanding + {7'd0, w_xfer} - {7'd0, w_doneHit};
  assign w_idNext    = w_xfer ? nextOpId(r_nextId) : r_nextId;
  assign w_avail     = (r_state == ISSUE) ? w_hasTwo : !w_empty;
  assign w_load      = (r_state == ISSUE) ? w_next : w_head;
  assign w_blocked   = (w_outNext >= MAX_OUT_L) || w_pendNext[w_idNext];
  assign w_issueOk   = en && w_avail && !w_blocked;
  assign w_validNext = ((r_state != ISSUE) || w_xfer) ? w_issueOk : 1'b1;

  // A presented request only changes on its transfer edge, never withdrawn.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 8'd0;
      r_data  <= 8'd0;
      r_opId  <= OP_ID_NONE;
    end else if ((r_state != ISSUE) || w_xfer) begin
      if (w_issueOk) begin
        r_state <= ISSUE;
        r_valid <= 1'b1;
        r_wr    <= w_load.wr;
        r_addr  <= w_load.addr;
        r_data  <= w_load.wr ? w_load.data : 8'd0;
        r_opId  <= w_idNext;
      end else begin
        r_state <= w_blocked ? STALL : IDLE;
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_started     <= 1'b0;
      r_enable      <= 1'b0;
      r_nextId      <= OP_ID_FIRST;
      r_outstanding <= 8'd0;
      r_pending     <= '0;
      r_wrflag      <= '0;
      r_timer       <= '0;
      r_rspValid    <= 1'b0;
      r_rspOpId     <= OP_ID_NONE;
      r_rspWr       <= 1'b0;
      r_rspRdData   <= 8'd0;
      r_errTimeout  <= 1'b0;
      r_errUnexp    <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      r_enable      <= en || (w_outNext != 8'd0) || w_validNext;
      r_nextId      <= w_idNext;
      r_outstanding <= w_outNext;
      r_pending     <= w_pendNext;
      if (w_xfer) r_wrflag[r_opId] <= r_wr;
      r_rspValid  <= w_doneHit;
      r_rspOpId   <= w_doneHit ? done_op_id : OP_ID_NONE;
      r_rspWr     <= w_doneHit && r_wrflag[done_op_id];
      r_rspRdData <= (w_doneHit && !r_wrflag[done_op_id]) ? rd_data_out : 8'd0;
      if (w_doneBad) r_errUnexp <= 1'b1;
      // Saturating watchdog: progress or an empty scoreboard restarts it.
      if (w_doneHit || (w_outNext == 8'd0)) r_timer <= '0;
      else if (r_timer != TIMEOUT_L)        r_timer <= r_timer + TW'(1);
      if (r_timer == TIMEOUT_L) r_errTimeout <= 1'b1;
    end
  end

  assign cmd_ready   = r_started && !w_full;
  assign enable_in   = r_enable;
  assign wr_rd_op    = r_wr;
  assign valid_in    = r_valid;
  assign addr_in     = r_addr;
  assign op_id_in    = r_opId;
  assign wr_data_in  = r_data;
  assign rsp_valid   = r_rspValid;
  assign rsp_op_id   = r_rspOpId;
  assign rsp_wr      = r_rspWr;
  assign rsp_rd_data = r_rspRdData;
  assign busy        = !w_empty || (r_outstanding != 8'd0) || r_valid;
  assign err_timeout = r_errTimeout;
  assign err_unexp   = r_errUnexp;

endmodule
